mips_datapath: RTL

// - Multicycle MIPS datapath: the receiving end of the control_unit interface. Consumes its

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mips_datapath_reg_file.sv | 23 ++
 rtl/mips_datapath.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings between the multicycle MIPS datapath and its controller
package mips_pkg;
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SRLV = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_sel_t;
  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alusrcb_t;
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_t;
  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
endpackage

// File: rtl/mips_datapath_reg_file.sv
// reg_file: 32x32 register file, two async read ports, one sync write port, $0 hardwired to zero
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] rf [32];
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];
  // clear everything on reset; writes to $0 are dropped so it always reads zero
  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (we && wa != 5'd0)
      rf[wa] <= wd;
  end
endmodule

// File: rtl/mips_datapath.sv
// mips_datapath: multicycle MIPS datapath driven by an external control unit
module mips_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCEn,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSource,
  input  logic [2:0]  ALUSel,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        zero,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [31:0] rd1, rd2, alu_a, alu_b, alu_y, pc_next, sext;
  assign sext      = {{16{ir[15]}}, ir[15:0]};
  assign alu_a     = ALUSrcA ? a : pc;
  assign opcode    = ir[31:26];
  assign func      = ir[5:0];
  assign zero      = (alu_y == 32'd0);
  assign mem_addr  = rst ? RESET_PC : (IorD ? alu_out : pc);
  assign mem_wdata = b;
  assign mem_read  = MemRead;
  assign mem_write = MemWrite & ~rst;
  // write index and data come from the current IR/MDR, so a same-edge IR load cannot redirect the write
  reg_file u_rf (
    .clk (clk),
    .rst (rst),
    .we  (RegWrite),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .wa  (RegDst ? ir[15:11] : ir[20:16]),
    .wd  (MemtoReg ? mdr : alu_out),
    .rd1 (rd1),
    .rd2 (rd2)
  );
  // ALU B-operand select
  always_comb begin
    alu_b = b;
    case (alusrcb_t'(ALUSrcB))
      SRCB_REG:    alu_b = b;
      SRCB_FOUR:   alu_b = 32'd4;
      SRCB_IMM:    alu_b = sext;
      SRCB_IMM_SH: alu_b = {sext[29:0], 2'b00};
    endcase
  end
  // 32-bit ALU; add/sub wrap, slt compares signed
  always_comb begin
    alu_y = '0;
    case (alu_sel_t'(ALUSel))
      ALU_AND:  alu_y = alu_a & alu_b;
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SRLV: alu_y = alu_b >> alu_a[4:0];
      ALU_NOR:  alu_y = ~(alu_a | alu_b);
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
    endcase
  end
  // next-PC select; jump keeps the top nibble of the already-incremented PC
  always_comb begin
    pc_next = pc;
    case (pcsrc_t'(PCSource))
      PCSRC_ALU:    pc_next = alu_y;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      PCSRC_HOLD:   pc_next = pc;
    endcase
  end
  // MDR/A/B/ALUOut capture every cycle; PC and IR only when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      mdr     <= mem_rdata;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_y;
      if (IRWrite) ir <= mem_rdata;
      if (PCEn) pc <= pc_next;
    end
  end
endmodule
